// File: rtl/instr_fetch_unit_if.sv
// Signal bundle between the fetch unit, instruction memory and decode.
// The master side belongs to the fetch unit. The slave side belongs to the memory/decode environment.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        decode_stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        misalign_err;

    modport master (
        output imem_req, imem_addr, instr_out, pc_out, instr_valid, misalign_err,
        input  imem_rdata, decode_stall, redirect, redirect_pc
    );

    modport slave (
        input  imem_req, imem_addr, instr_out, pc_out, instr_valid, misalign_err,
        output imem_rdata, decode_stall, redirect, redirect_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end. It owns the PC and issues reads to a 1-cycle synchronous instruction memory.
// Returned words go into a 2-entry FIFO, and the FIFO head is presented to decode.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  bus
);
    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } entry_t;

    // Slot 0 is always the head. Its pc field is left untouched when the FIFO drains,
    // so pc_out keeps the last presented address for free.
    entry_t [1:0] slot_q, slot_d;
    logic   [1:0] occ_q, occ_d;
    logic         inflight_q;
    logic  [31:0] req_addr_q;
    logic  [31:0] pc_q, pc_d;
    logic         mis_q;

    logic         pop, push, req;
    logic   [2:0] demand;
    entry_t       rsp;

    assign pop    = (occ_q != 2'd0) & ~bus.decode_stall;
    // A redirect kills the response landing in the same cycle and blocks any issue in that cycle.
    // Nothing is in flight in the following cycle, so no separate discard flag is needed.
    assign push   = inflight_q & ~bus.redirect;
    assign demand = {1'b0, occ_q} + {2'b00, inflight_q};
    assign req    = ~rst & ~bus.redirect & (demand < (3'd2 + {2'b00, pop}));
    assign rsp    = '{instr: bus.imem_rdata, pc: req_addr_q};

    always_comb begin
        slot_d = slot_q;
        occ_d  = occ_q;
        if (bus.redirect) begin
            occ_d = 2'd0;
        end else begin
            case ({push, pop})
                2'b01: begin
                    if (occ_q == 2'd2) slot_d[0] = slot_q[1];
                    occ_d = occ_q - 2'd1;
                end
                2'b10: begin
                    slot_d[occ_q[0]] = rsp;
                    occ_d = occ_q + 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd2) begin
                        slot_d[0] = slot_q[1];
                        slot_d[1] = rsp;
                    end else begin
                        slot_d[0] = rsp;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        pc_d = pc_q;
        if (bus.redirect)
            pc_d = {bus.redirect_pc[31:2], 2'b00};
        else if (req)
            pc_d = pc_q + 32'd4;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            occ_q      <= 2'd0;
            slot_q     <= '0;
            inflight_q <= 1'b0;
            req_addr_q <= 32'd0;
            mis_q      <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            occ_q      <= occ_d;
            slot_q     <= slot_d;
            inflight_q <= req;
            req_addr_q <= pc_q;
            mis_q      <= bus.redirect & (bus.redirect_pc[1:0] != 2'b00);
        end
    end

    assign bus.imem_req     = req;
    assign bus.imem_addr    = pc_q;
    assign bus.instr_valid  = (occ_q != 2'd0);
    assign bus.instr_out    = (occ_q != 2'd0) ? slot_q[0].instr : NOP_INSTR;
    assign bus.pc_out       = slot_q[0].pc;
    assign bus.misalign_err = mis_q;
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit. A queue-based model of fetch, stall, redirect and reset is checked every cycle.
// Directed phases follow the test plan, and a randomized phase runs after them.
module tb_instr_fetch_unit;
    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    instr_fetch_unit_if bus();
    instr_fetch_unit #(.RESET_PC(RST_PC), .NOP_INSTR(NOP)) dut (
        .clk(clk), .rst(rst), .bus(bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
    ent_t        mq[$];
    logic [31:0] m_pc, m_last_pc, m_fl_addr;
    bit          m_fl, m_mis;
    bit          pend;
    logic [31:0] pend_addr;

    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0100: return 32'h0050_0093;
            32'h0000_0104: return 32'h00A0_0113;
            32'h0000_0108: return 32'h0020_81B3;
            32'h0000_010C: return 32'h0030_2023;
            default:       return {a[15:0] ^ 16'h5A5A, a[31:16]};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_pc      = RST_PC;
        m_last_pc = 32'd0;
        m_fl      = 1'b0;
        m_mis     = 1'b0;
    endtask

    // One clock cycle: drive inputs, compare DUT outputs with the model, then advance the model past the edge.
    task automatic step(input bit st, input bit rd, input logic [31:0] rpc, input bit r);
        bit          ev, pop, er;
        int          demand;
        logic [31:0] exp_pc;
        @(negedge clk);
        bus.imem_rdata   = pend ? memf(pend_addr) : $urandom;
        bus.decode_stall = st;
        bus.redirect     = rd;
        bus.redirect_pc  = rpc;
        rst              = r;
        #1;
        ev     = (mq.size() != 0);
        pop    = ev && !st;
        demand = mq.size() + int'(m_fl) - int'(pop);
        er     = !r && !rd && (demand < 2);
        exp_pc = ev ? mq[0].pc : m_last_pc;
        chk("instr_valid", {31'd0, bus.instr_valid}, {31'd0, ev});
        chk("instr_out", bus.instr_out, ev ? mq[0].instr : NOP);
        chk("pc_out", bus.pc_out, exp_pc);
        chk("imem_req", {31'd0, bus.imem_req}, {31'd0, er});
        if (er) chk("imem_addr", bus.imem_addr, m_pc);
        chk("misalign_err", {31'd0, bus.misalign_err}, {31'd0, m_mis});
        pend      = bus.imem_req;
        pend_addr = bus.imem_addr;

        m_last_pc = exp_pc;
        if (r) begin
            model_reset();
        end else if (rd) begin
            mq.delete();
            m_fl  = 1'b0;
            m_pc  = {rpc[31:2], 2'b00};
            m_mis = (rpc[1:0] != 2'b00);
        end else begin
            m_mis = 1'b0;
            if (pop) void'(mq.pop_front());
            if (m_fl) begin
                // An arriving word must always find a free entry.
                checks++;
                if (mq.size() >= 2) begin
                    errors++;
                    $display("FAIL fifo_overflow occupancy %0d expected below 2", mq.size());
                end else begin
                    mq.push_back('{instr: memf(m_fl_addr), pc: m_fl_addr});
                end
            end
            m_fl      = er;
            m_fl_addr = m_pc;
            if (er) m_pc = m_pc + 32'd4;
        end
    endtask

    initial begin
        rst              = 1'b1;
        bus.decode_stall = 1'b0;
        bus.redirect     = 1'b0;
        bus.redirect_pc  = 32'd0;
        bus.imem_rdata   = 32'd0;
        pend             = 1'b0;
        pend_addr        = 32'd0;
        repeat (2) @(posedge clk);
        model_reset();
        step(0, 0, 0, 1);

        // Reset release: cycle 0 issues 0x100, and the first valid word appears in cycle 2.
        step(0, 0, 0, 0);
        chk("lit_req_c0", {31'd0, bus.imem_req}, 32'd1);
        chk("lit_addr_c0", bus.imem_addr, 32'h100);
        step(0, 0, 0, 0);
        chk("lit_valid_c1", {31'd0, bus.instr_valid}, 32'd0);
        step(0, 0, 0, 0);
        chk("lit_pc_c2", bus.pc_out, 32'h100);
        chk("lit_instr_c2", bus.instr_out, 32'h0050_0093);

        // Stall with 0x104 at the head.
        for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0);
            chk("lit_stall_pc", bus.pc_out, 32'h104);
            chk("lit_stall_req", {31'd0, bus.imem_req}, 32'd0);
        end
        step(0, 0, 0, 0);
        chk("lit_release_instr", bus.instr_out, 32'h00A0_0113);

        // Redirect to 0x200 while 0x108 is at the head.
        step(0, 1, 32'h200, 0);
        chk("lit_redir_head", bus.pc_out, 32'h108);
        step(0, 0, 0, 0);
        chk("lit_redir_r1", {31'd0, bus.instr_valid}, 32'd0);
        step(0, 0, 0, 0);
        chk("lit_redir_r2", {31'd0, bus.instr_valid}, 32'd0);
        step(0, 0, 0, 0);
        chk("lit_redir_r3", bus.pc_out, 32'h200);
        repeat (3) step(0, 0, 0, 0);

        // Misaligned target.
        step(0, 1, 32'h206, 0);
        step(0, 0, 0, 0);
        chk("lit_mis_r1", {31'd0, bus.misalign_err}, 32'd1);
        step(0, 0, 0, 0);
        chk("lit_mis_r2", {31'd0, bus.misalign_err}, 32'd0);
        step(0, 0, 0, 0);
        chk("lit_mis_pc", bus.pc_out, 32'h204);

        // PC wrap.
        step(0, 1, 32'hFFFF_FFFC, 0);
        repeat (3) step(0, 0, 0, 0);
        chk("lit_wrap_a", bus.pc_out, 32'hFFFF_FFFC);
        step(0, 0, 0, 0);
        chk("lit_wrap_b", bus.pc_out, 32'h0000_0000);

        // One-cycle reset mid-stream with stall active.
        step(1, 0, 0, 0);
        step(1, 0, 0, 0);
        step(1, 0, 0, 1);
        step(0, 0, 0, 0);
        chk("lit_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("lit_rst_instr", bus.instr_out, NOP);
        chk("lit_rst_pc", bus.pc_out, 32'd0);
        chk("lit_rst_addr", bus.imem_addr, RST_PC);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        chk("lit_rst_first", bus.pc_out, 32'h100);
        chk("lit_rst_first_i", bus.instr_out, 32'h0050_0093);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit          st, rd, r;
            logic [31:0] rpc;
            r   = ($urandom % 200) == 0;
            rd  = ($urandom % 20) == 0;
            st  = ($urandom % 3) == 0;
            rpc = (($urandom % 4) == 0) ? (32'hFFFF_FFF0 | ($urandom % 16)) : $urandom;
            step(st, rd, rpc, r);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Front-end stage directly upstream of the instruction decoder.
- Owns the program counter and issues word reads to a synchronous instruction memory with 1-cycle read latency.
- Buffers returned words in a 2-entry FIFO and presents {instruction, pc} to decode with a valid/stall handshake.
- Handles taken-branch/jump redirects from execute, flushing wrong-path fetches.

Parameters:
RESET_PC  32'h0000_0000  PC value loaded on reset
NOP_INSTR  32'h0000_0013  value driven on instr_out while FIFO empty (addi x0,x0,0)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  synchronous active-high reset
imem_req  output  1  read request to instruction memory this cycle
imem_addr  output  32  byte address of request, bits[1:0] always 0
imem_rdata  input  32  read data, valid the cycle after imem_req
decode_stall  input  1  decoder cannot accept this cycle
redirect  input  1  taken branch/jal/jalr from execute
redirect_pc  input  32  target address for redirect
instr_out  output  32  instruction to decoder (FIFO head)
pc_out  output  32  address of instr_out
instr_valid  output  1  instr_out/pc_out are valid
misalign_err  output  1  one-cycle pulse: redirect target had bits[1:0] != 0

Behaviour:
- Clock is clk; reset is synchronous, active-high; rst has priority over every other input.
- Reset values:
  - pc = RESET_PC; FIFO empty; in-flight flag = 0; discard flag = 0.
  - imem_req = 0; instr_valid = 0; instr_out = NOP_INSTR; pc_out = 0; misalign_err = 0.
- Reset mid-operation: FIFO cleared, any in-flight response dropped; no output change until the normal fetch latency elapses.
- Occupancy and popping:
  - occ = FIFO entries (0..2); inflight = 1 if a request was issued last cycle and is not being discarded.
  - pop = instr_valid & ~decode_stall.
- Issue rule:
  - imem_req = ~rst & ~redirect & (occ + inflight − pop < 2).
  - On issue: imem_addr = pc, and pc <= pc + 4 (32-bit, wraps 0xFFFF_FFFC -> 0x0000_0000).
  - This rule guarantees FIFO never overflows while sustaining 1 instr/cycle when decode_stall = 0.
- Response capture: cycle after an issue, imem_rdata and its address are pushed into the FIFO unless discard is set.
- Latency: request in cycle N -> instr_valid = 1 with that word in cycle N+2.
  - First instr_valid after rst deasserts (rst low in cycle 0, req in cycle 0) appears in cycle 2.
- Outputs are registered FIFO head.
  - instr_valid = (occ != 0).
  - While empty: instr_out = NOP_INSTR, pc_out holds last value.
- Stall: while decode_stall = 1, instr_out/pc_out/instr_valid hold; no pop. Issue stops once occ + inflight reaches 2. No data loss, no duplication.
- Redirect (cycle R):
  - FIFO flushed at end of R.
  - Response arriving in R+1 is discarded.
  - No request in R.
  - pc <= {redirect_pc[31:2], 2'b00}.
  - Request to target issued in R+1; instr_valid = 0 in R+1 and R+2; target instr valid in R+3.
- Redirect overrides decode_stall and any simultaneous response or pop.
- Back-to-back redirects: the last one wins; each restarts the R+3 timing.
- Misaligned target: if redirect_pc[1:0] != 0, misalign_err = 1 in R+1 only; fetch proceeds from the word-aligned address.
- Simultaneous push and pop with occ = 2: not reachable under the issue rule. An assertion in the bench checks it never occurs.

Test Plan:
- Reset release, RESET_PC=0x100, mem[0x100..0x10C] = 0x00500093,0x00A00113,0x002081B3,0x00302023, no stall -> instr_valid high from cycle 2; pc_out 0x100,0x104,0x108,0x10C on consecutive cycles with matching instr_out.
- Stream running, decode_stall high for 5 cycles starting with 0x104 at head -> outputs hold 0x104; imem_req low after 2 outstanding; on release 0x104,0x108,0x10C follow with no gaps or repeats.
- redirect=1, redirect_pc=0x200 in cycle R while 0x108 at head -> instr_valid low R+1,R+2; pc_out=0x200 valid R+3; 0x10C never presented.
- redirect with redirect_pc=0x0000_0206 -> misalign_err pulses in R+1 only; fetch from 0x204.
- pc wrap: redirect to 0xFFFF_FFFC -> next pc_out values 0xFFFF_FFFC then 0x0000_0000.
- rst asserted for one cycle mid-stream with stall active -> all outputs at reset values next cycle; fetch restarts at RESET_PC, old in-flight data never appears.
